mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: icache and dcache share one RAM, with one
// transaction in flight, dcache priority, and a starvation guard for icache.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISERV = 2'b01;
    localparam logic [1:0] DSERV = 2'b10;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    logic [1:0]    state, state_next;
    logic [SW-1:0] starve;
    logic          d_req, starved, i_done, d_done, ram_end;

    assign d_req   = dREN | dWEN;
    assign starved = iREN && (starve == SW'(STARVE_MAX));
    assign ram_end = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    // A completion only counts while the granted requester still asks for it.
    assign i_done  = (state == ISERV) && iREN  && (ramstate == RAM_ACCESS);
    assign d_done  = (state == DSERV) && d_req && (ramstate == RAM_ACCESS);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req && !starved)
                    state_next = DSERV;
                else if (iREN)
                    state_next = ISERV;
            end
            ISERV: if (!iREN || ram_end) state_next = IDLE;
            DSERV: if (!d_req || ram_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state)
            ISERV: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (i_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = !dWEN;
                if (d_done) begin
                    dwait = 1'b0;
                    if (!dWEN)
                        dload = ramload;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state <= state_next;
            if (!iREN || i_done)
                starve <= '0;
            else if (d_done && starve != SW'(STARVE_MAX))
                starve <= starve + 1'b1;
        end
    end
endmodule
